// File: rtl/button_debouncer_pkg.sv
// Shared bring-up definitions: debouncer state encoding and default timing constants.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    CHECK_PRESS,
    PRESSED,
    CHECK_RELEASE
  } deb_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 1000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 50000;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Generic two-flop synchronizer; the reset value lets the caller pick the idle level of the line.
module button_debouncer_sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle out of metastability.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes the raw pin, debounces it, and produces a clean level,
// one-cycle press/release/long-press events and a blink enable toggled by short presses.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic blink_enable
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

  // The synchronizer idles at the not-pressed pin level so reset never looks like a press.
  localparam logic IDLE_LEVEL = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic sync_q;
  logic p;

  deb_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [HOLD_W-1:0] hold, hold_next;
  logic              long_fired, long_fired_next;
  logic              level_next;
  logic              press_next, release_next, long_next;
  logic              blink_next;

  button_debouncer_sync_2ff #(
    .RESET_VALUE(IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync_q)
  );

  assign p = BTN_ACTIVE_LOW ? ~sync_q : sync_q;

  // Registers for the FSM, its counters, and every output so pulses are glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= RELEASED;
      cnt              <= '0;
      hold             <= '0;
      long_fired       <= 1'b0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      blink_enable     <= 1'b0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      hold             <= hold_next;
      long_fired       <= long_fired_next;
      btn_level        <= level_next;
      press_pulse      <= press_next;
      release_pulse    <= release_next;
      long_press_pulse <= long_next;
      blink_enable     <= blink_next;
    end
  end

  // Next-state logic: qualify level changes, run the hold timer while pressed, decide the blink toggle.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    hold_next       = hold;
    long_fired_next = long_fired;
    level_next      = btn_level;
    press_next      = 1'b0;
    release_next    = 1'b0;
    long_next       = 1'b0;
    blink_next      = blink_enable;

    case (state)
      RELEASED: begin
        if (p) begin
          state_next = CHECK_PRESS;
          cnt_next   = CNT_ONE;
        end
      end

      CHECK_PRESS: begin
        if (!p) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          hold_next  = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!p) begin
          state_next = CHECK_RELEASE;
          cnt_next   = CNT_ONE;
        end else if (hold != HOLD_MAX) begin
          hold_next = hold + HOLD_ONE;
          if (hold == HOLD_LAST && !long_fired) begin
            long_next       = 1'b1;
            blink_next      = 1'b0;
            long_fired_next = 1'b1;
          end
        end
      end

      CHECK_RELEASE: begin
        if (p) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next      = RELEASED;
          cnt_next        = '0;
          level_next      = 1'b0;
          release_next    = 1'b1;
          long_fired_next = 1'b0;
          if (!long_fired) begin
            blink_next = ~blink_enable;
          end
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

endmodule
